// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: stalls, flushes, forward selects, freeze.
// Optional operand forwarding is enabled by defining PIPE_FORWARDING_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       OpCodeD,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RdD,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCycles
);

    typedef struct packed {
        logic             valid;
        logic             we;
        logic             is_load;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] ra1;
        logic [REG_W-1:0] ra2;
        logic             use1;
        logic             use2;
    } trk_t;

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    trk_t             dec;
    trk_t             e_q, e_d, m_q, m_d, w_q, w_d;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             freeze, branch, hazard, hazard_raw;

    function automatic logic hit(trk_t t, logic [REG_W-1:0] src, logic use_src);
        return t.valid & t.we & use_src & (t.rd == src);
    endfunction

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.rd    = RdD;
        dec.ra1   = RA1D;
        dec.ra2   = RA2D;
        case (OpCodeD)
            4'b0100, 4'b0101: begin
                dec.we      = 1'b1;
                dec.is_load = 1'b1;
                dec.use1    = 1'b1;
            end
            4'b0110, 4'b0111: begin
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
            end
            4'b1000, 4'b1010, 4'b1011, 4'b1100: begin
                dec.we   = 1'b1;
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
            end
            4'b1001: begin
                dec.we   = 1'b1;
                dec.use1 = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PIPE_FORWARDING_EN
    always_comb begin
        hazard_raw = e_q.is_load & (hit(e_q, RA1D, dec.use1) | hit(e_q, RA2D, dec.use2));
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        if (rst_n) begin
            if (hit(m_q, e_q.ra1, e_q.use1))      ForwardAE = 2'b10;
            else if (hit(w_q, e_q.ra1, e_q.use1)) ForwardAE = 2'b01;
            if (hit(m_q, e_q.ra2, e_q.use2))      ForwardBE = 2'b10;
            else if (hit(w_q, e_q.ra2, e_q.use2)) ForwardBE = 2'b01;
        end
    end
`else
    // W is excluded: the register file writes through to same-cycle reads.
    always_comb begin
        hazard_raw = hit(e_q, RA1D, dec.use1) | hit(e_q, RA2D, dec.use2) |
                     hit(m_q, RA1D, dec.use1) | hit(m_q, RA2D, dec.use2);
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
    end
`endif

    // Priority: reset, then memory freeze, then taken branch, then data hazard.
    always_comb begin
        freeze = rst_n & MemReqM & ~MemReadyM;
        branch = rst_n & ~freeze & BranchTakenE;
        hazard = rst_n & ~freeze & ~branch & hazard_raw;
        StallF = freeze | hazard;
        StallD = freeze | hazard;
        StallE = freeze;
        StallM = freeze;
        FlushD = branch;
        FlushE = branch | hazard;
        FlushW = freeze;
    end

    always_comb begin
        e_d = e_q;
        if (!StallE) begin
            e_d = dec;
            if (FlushE) e_d.valid = 1'b0;
        end
        m_d = StallM ? m_q : e_q;
        w_d = m_q;
        if (FlushW) w_d.valid = 1'b0;
        cnt_d = cnt_q;
        if (StallF && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            state_q <= StRun;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
            case (state_q)
                StRun:     if (MemReqM && !MemReadyM) state_q <= StMemWait;
                StMemWait: if (MemReadyM) state_q <= StRun;
                default:   state_q <= StRun;
            endcase
        end
    end

    assign StallCycles = cnt_q;

    logic unused_w;
    assign unused_w = ^w_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow PIPE_FORWARDING_EN if defined.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpLoad = 4'b0100;
    localparam logic [3:0] OpAdd  = 4'b1000;
    localparam logic [3:0] OpSub  = 4'b1010;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] CtlNone = 7'b0000000;
    localparam logic [6:0] CtlHaz  = 7'b1100010;
    localparam logic [6:0] CtlFrz  = 7'b1111001;
    localparam logic [6:0] CtlBr   = 7'b0000110;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       OpCodeD = '0;
    logic [REG_W-1:0] RA1D = '0, RA2D = '0, RdD = '0;
    logic             BranchTakenE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCycles;

    int n_pass  = 0;
    int n_total = 0;

    wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    wire [3:0] fwd = {ForwardAE, ForwardBE};

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .OpCodeD(OpCodeD), .RA1D(RA1D), .RA2D(RA2D), .RdD(RdD),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    // One cycle: drive at the falling edge, settle, caller samples before the next rising edge.
    task automatic step(input logic rn, input logic [3:0] op, input logic [REG_W-1:0] a1,
                        input logic [REG_W-1:0] a2, input logic [REG_W-1:0] rd,
                        input logic br, input logic req, input logic rdy);
        @(negedge clk);
        rst_n = rn; OpCodeD = op; RA1D = a1; RA2D = a2; RdD = rd;
        BranchTakenE = br; MemReqM = req; MemReadyM = rdy;
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, OpAdd, 1, 2, 3, 1'b1, 1'b1, 1'b0);
        n_total++; if ({ctl, fwd} !== 11'd0) $display("FAIL rst_out0 got=%b exp=0", {ctl, fwd}); else n_pass++;
        step(1'b0, OpAdd, 1, 2, 3, 1'b1, 1'b1, 1'b0);
        n_total++; if ({ctl, fwd} !== 11'd0) $display("FAIL rst_out1 got=%b exp=0", {ctl, fwd}); else n_pass++;
        n_total++; if (StallCycles !== 4'd0) $display("FAIL rst_cnt got=%0d exp=0", StallCycles); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        n_total++; if (ctl !== CtlFrz) $display("FAIL rst_release ctl=%b exp=%b", ctl, CtlFrz); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        n_total++; if (StallCycles !== 4'd1) $display("FAIL rst_cnt1 got=%0d exp=1", StallCycles); else n_pass++;
        step(1'b0, OpNop, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL rst_in_wait ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpAdd, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL rst_resume ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        n_total++; if (StallCycles !== 4'd0) $display("FAIL rst_cnt_clr got=%0d exp=0", StallCycles); else n_pass++;
    endtask

    task automatic test_forward();
        do_reset();
        step(1'b1, OpAdd, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpSub, 3, 5, 4, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_FORWARDING_EN
        n_total++; if (ctl !== CtlNone) $display("FAIL fwd_b2b_ctl ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (fwd !== 4'b1000) $display("FAIL fwd_b2b_sel got=%b exp=1000", fwd); else n_pass++;
`else
        n_total++; if (ctl !== CtlHaz) $display("FAIL fwd_b2b_ctl ctl=%b exp=%b", ctl, CtlHaz); else n_pass++;
        step(1'b1, OpSub, 3, 5, 4, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlHaz) $display("FAIL fwd_b2b_ctl2 ctl=%b exp=%b", ctl, CtlHaz); else n_pass++;
        step(1'b1, OpSub, 3, 5, 4, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL fwd_b2b_ctl3 ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (fwd !== 4'b0000) $display("FAIL fwd_b2b_sel got=%b exp=0000", fwd); else n_pass++;
        n_total++; if (StallCycles !== 4'd2) $display("FAIL fwd_b2b_cnt got=%0d exp=2", StallCycles); else n_pass++;
`endif
        do_reset();
        step(1'b1, OpAdd, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpSub, 3, 5, 4, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_FORWARDING_EN
        n_total++; if (ctl !== CtlNone) $display("FAIL fwd_gap_ctl ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (fwd !== 4'b0100) $display("FAIL fwd_gap_sel got=%b exp=0100", fwd); else n_pass++;
        n_total++; if (StallCycles !== 4'd0) $display("FAIL fwd_gap_cnt got=%0d exp=0", StallCycles); else n_pass++;
`else
        n_total++; if (ctl !== CtlHaz) $display("FAIL fwd_gap_ctl ctl=%b exp=%b", ctl, CtlHaz); else n_pass++;
        step(1'b1, OpSub, 3, 5, 4, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL fwd_gap_ctl2 ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (fwd !== 4'b0000) $display("FAIL fwd_gap_sel got=%b exp=0000", fwd); else n_pass++;
        n_total++; if (StallCycles !== 4'd1) $display("FAIL fwd_gap_cnt got=%0d exp=1", StallCycles); else n_pass++;
`endif
    endtask

    task automatic test_load_use();
        do_reset();
        step(1'b1, OpLoad, 7, 0, 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpAdd, 2, 2, 1, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlHaz) $display("FAIL lu_stall1 ctl=%b exp=%b", ctl, CtlHaz); else n_pass++;
        step(1'b1, OpAdd, 2, 2, 1, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_FORWARDING_EN
        n_total++; if (ctl !== CtlNone) $display("FAIL lu_go ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (fwd !== 4'b0101) $display("FAIL lu_fwd got=%b exp=0101", fwd); else n_pass++;
        n_total++; if (StallCycles !== 4'd1) $display("FAIL lu_cnt got=%0d exp=1", StallCycles); else n_pass++;
`else
        n_total++; if (ctl !== CtlHaz) $display("FAIL lu_stall2 ctl=%b exp=%b", ctl, CtlHaz); else n_pass++;
        step(1'b1, OpAdd, 2, 2, 1, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL lu_go ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (fwd !== 4'b0000) $display("FAIL lu_fwd got=%b exp=0000", fwd); else n_pass++;
        n_total++; if (StallCycles !== 4'd2) $display("FAIL lu_cnt got=%0d exp=2", StallCycles); else n_pass++;
`endif
    endtask

    task automatic test_branch_collision();
        do_reset();
        step(1'b1, OpLoad, 7, 0, 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpAdd, 2, 2, 1, 1'b1, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlBr) $display("FAIL br_wins ctl=%b exp=%b", ctl, CtlBr); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL br_after ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        n_total++; if (StallCycles !== 4'd0) $display("FAIL br_cnt got=%0d exp=0", StallCycles); else n_pass++;
    endtask

    task automatic test_decode();
        do_reset();
        step(1'b1, 4'b1101, 5, 5, 5, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpAdd, 5, 5, 1, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL dec_undef ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, 4'b1100, 3, 4, 5, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpAdd, 5, 0, 6, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_FORWARDING_EN
        n_total++; if (ctl !== CtlNone) $display("FAIL dec_1100 ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
`else
        n_total++; if (ctl !== CtlHaz) $display("FAIL dec_1100 ctl=%b exp=%b", ctl, CtlHaz); else n_pass++;
`endif
    endtask

    task automatic test_mem_wait();
        logic [REG_W-1:0] base;
`ifdef PIPE_FORWARDING_EN
        base = 4'd9;
`else
        base = 4'd8;
`endif
        do_reset();
        step(1'b1, OpAdd, 1, 2, 9, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpAdd, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, OpLoad, base, 0, 6, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL mw_pre ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        step(1'b1, OpSub, 6, 5, 4, 1'b0, 1'b1, 1'b0);
        n_total++; if (ctl !== CtlFrz) $display("FAIL mw_frz1 ctl=%b exp=%b", ctl, CtlFrz); else n_pass++;
`ifdef PIPE_FORWARDING_EN
        n_total++; if (fwd !== 4'b0100) $display("FAIL mw_wfwd1 got=%b exp=0100", fwd); else n_pass++;
`endif
        step(1'b1, OpSub, 6, 5, 4, 1'b0, 1'b1, 1'b0);
        n_total++; if (ctl !== CtlFrz) $display("FAIL mw_frz2 ctl=%b exp=%b", ctl, CtlFrz); else n_pass++;
        n_total++; if (fwd !== 4'b0000) $display("FAIL mw_wlost got=%b exp=0000", fwd); else n_pass++;
        step(1'b1, OpSub, 6, 5, 4, 1'b1, 1'b1, 1'b0);
        n_total++; if (ctl !== CtlFrz) $display("FAIL mw_frz_br ctl=%b exp=%b", ctl, CtlFrz); else n_pass++;
        step(1'b1, OpSub, 6, 5, 4, 1'b1, 1'b1, 1'b1);
        n_total++; if (ctl !== CtlBr) $display("FAIL mw_br_late ctl=%b exp=%b", ctl, CtlBr); else n_pass++;
        n_total++; if (StallCycles !== 4'd3) $display("FAIL mw_cnt got=%0d exp=3", StallCycles); else n_pass++;
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (ctl !== CtlNone) $display("FAIL mw_after ctl=%b exp=%b", ctl, CtlNone); else n_pass++;
        n_total++; if (StallCycles !== 4'd3) $display("FAIL mw_cnt2 got=%0d exp=3", StallCycles); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b1, 1'b0);
            exp_cnt = (i < 15) ? CNT_W'(i) : 4'd15;
            n_total++;
            if (StallCycles !== exp_cnt) $display("FAIL sat_%0d got=%0d exp=%0d", i, StallCycles, exp_cnt);
            else n_pass++;
        end
        step(1'b1, OpNop, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        n_total++; if (StallCycles !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", StallCycles); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch_collision();
        test_decode();
        test_mem_wait();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
